// File: rtl/ripple_adder4_struct.sv
// Registered WIDTH-bit ripple-carry adder built from gate-level full-adder cells; reports carry and signed overflow.
// Latency 1: operands qualified by in_valid at one rising edge appear on Sum/Cout/Ovf with out_valid after that edge.
// No backpressure: accepts a new operand set every cycle; with in_valid low the result registers hold and out_valid drops.

// One-bit full adder from gate primitives: s = a^b^c, co = a&b | c&(a^b).
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    logic p;
    logic g;
    logic t;

    xor u_xor_p (p, a_i, b_i);
    xor u_xor_s (s_o, p, c_i);
    and u_and_g (g, a_i, b_i);
    and u_and_t (t, c_i, p);
    or  u_or_co (co_o, g, t);
endmodule

module ripple_adder4_struct #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             out_valid
);
    // c[i] is the carry into cell i; c[WIDTH] leaves the MSB cell.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        fa_cell u_fa (
            .a_i  (A[i]),
            .b_i  (B[i]),
            .c_i  (c[i]),
            .s_o  (s[i]),
            .co_o (c[i+1])
        );
    end

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             vld_q, vld_d;

    // Load a new result only when qualified; otherwise keep the last one so
    // garbage (including X) on idle operands never reaches the outputs.
    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        vld_d  = in_valid;
        if (in_valid) begin
            sum_d  = s;
            cout_d = c[WIDTH];
            ovf_d  = c[WIDTH-1] ^ c[WIDTH];
        end
    end

    // Output registers; reset clears immediately without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            vld_q  <= vld_d;
        end
    end

    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;
    assign out_valid = vld_q;
endmodule

// File: tb/tb_ripple_adder4_struct.sv
// Self-checking bench for ripple_adder4_struct: directed table, reset/hold sequences,
// exhaustive 512-combination sweep and random stimulus against an arithmetic model.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_ripple_adder4_struct;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] Sum;
    logic       Cout;
    logic       Ovf;
    logic       out_valid;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ripple_adder4_struct #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf),
        .out_valid (out_valid)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    // Reference: exact integer sum for {Cout,Sum}; overflow when the signed
    // interpretation of A + B + Cin leaves the 4-bit range -8..7.
    function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic cin);
        int u;
        int sa;
        int sb;
        int sr;
        logic [4:0] uv;
        logic       ov;
        u  = int'(a) + int'(b) + int'(cin);
        sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
        sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
        sr = sa + sb + int'(cin);
        ov = (sr > 7) || (sr < -8);
        uv = u[4:0];
        return {ov, uv};
    endfunction

    task automatic check(input string nm, input logic [3:0] es, input logic ec,
                         input logic eo, input logic ev);
        n_vec++;
        if (Sum !== es || Cout !== ec || Ovf !== eo || out_valid !== ev) begin
            n_bad++;
            $display("FAIL %s: got sum=%b cout=%b ovf=%b vld=%b, want sum=%b cout=%b ovf=%b vld=%b",
                     nm, Sum, Cout, Ovf, out_valid, es, ec, eo, ev);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic cin);
        @(negedge clk);
        in_valid = v;
        A        = a;
        B        = b;
        Cin      = cin;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    vec_t       tbl[7];
    logic [5:0] m;
    logic [3:0] h_sum;
    logic       h_cout;
    logic       h_ovf;

    initial begin
        tbl[0] = '{a: 4'b0000, b: 4'b0000, cin: 1'b0, sum: 4'b0000, cout: 1'b0, ovf: 1'b0};
        tbl[1] = '{a: 4'b0110, b: 4'b0110, cin: 1'b0, sum: 4'b1100, cout: 1'b0, ovf: 1'b1};
        tbl[2] = '{a: 4'b0111, b: 4'b0111, cin: 1'b0, sum: 4'b1110, cout: 1'b0, ovf: 1'b1};
        tbl[3] = '{a: 4'b1011, b: 4'b1011, cin: 1'b0, sum: 4'b0110, cout: 1'b1, ovf: 1'b1};
        tbl[4] = '{a: 4'b1100, b: 4'b1100, cin: 1'b0, sum: 4'b1000, cout: 1'b1, ovf: 1'b0};
        tbl[5] = '{a: 4'b1111, b: 4'b1111, cin: 1'b1, sum: 4'b1111, cout: 1'b1, ovf: 1'b0};
        tbl[6] = '{a: 4'b1111, b: 4'b0000, cin: 1'b1, sum: 4'b0000, cout: 1'b1, ovf: 1'b0};

        // Reset held with random, valid-qualified inputs across several edges.
        rst      = 1'b1;
        in_valid = 1'b1;
        A        = 4'($urandom);
        B        = 4'($urandom);
        Cin      = 1'($urandom);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
            after_edge();
            check("reset_hold", 4'b0000, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed table, back-to-back.
        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin);
            after_edge();
            check($sformatf("table[%0d]", i), tbl[i].sum, tbl[i].cout, tbl[i].ovf, 1'b1);
        end

        // Hold: idle cycle with different (and then unknown) operands keeps the result.
        drive(1'b1, 4'b0011, 4'b0001, 1'b0);
        after_edge();
        check("hold_load", 4'b0100, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 4'b1111, 4'b1111, 1'b1);
        after_edge();
        check("hold_idle", 4'b0100, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'bxxxx, 4'bxxxx, 1'bx);
        after_edge();
        check("hold_x", 4'b0100, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges clears without a clock.
        drive(1'b1, 4'b1011, 4'b1011, 1'b0);
        after_edge();
        check("pre_async", 4'b0110, 1'b1, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_clear", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Result pending at the edge where rst is high is discarded.
        drive(1'b1, 4'b0111, 4'b0111, 1'b0);
        after_edge();
        check("pending_discard", 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        A   = 4'b0101;
        B   = 4'b0010;
        Cin = 1'b1;
        after_edge();
        check("first_after_reset", 4'b1000, 1'b0, 1'b1, 1'b1);

        // Exhaustive sweep, one operand set per cycle.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    drive(1'b1, 4'(a), 4'(b), 1'(c));
                    after_edge();
                    m = model(4'(a), 4'(b), 1'(c));
                    check($sformatf("exh a=%0d b=%0d c=%0d", a, b, c), m[3:0], m[4], m[5], 1'b1);
                end
            end
        end
        h_sum  = m[3:0];
        h_cout = m[4];
        h_ovf  = m[5];

        // Random stimulus with random qualification; model tracks held values.
        for (int i = 0; i < 300; i++) begin
            logic       v;
            logic [3:0] a;
            logic [3:0] b;
            logic       c;
            v = ($urandom_range(0, 9) < 7);
            a = 4'($urandom);
            b = 4'($urandom);
            c = 1'($urandom);
            drive(v, a, b, c);
            after_edge();
            if (v) begin
                m      = model(a, b, c);
                h_sum  = m[3:0];
                h_cout = m[4];
                h_ovf  = m[5];
            end
            check($sformatf("rand[%0d]", i), h_sum, h_cout, h_ovf, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
